// File: rtl/nios_mul_if.sv
// Request/response handshake bundle between a multiply client and nios_mul_result_stage.
// The master drives requests and accepts responses; the slave is the result stage.
interface nios_mul_if #(
    parameter int TAG_W = 5
) ();
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [TAG_W-1:0] req_tag;
    logic [31:0]      req_src1;
    logic [31:0]      req_src2;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic [TAG_W-1:0] rsp_tag;

    modport master (
        output req_valid, req_op, req_tag, req_src1, req_src2, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_tag
    );

    modport slave (
        input  req_valid, req_op, req_tag, req_src1, req_src2, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_tag
    );
endinterface

// File: rtl/nios_mul_result_stage.sv
// Issue/result stage around the two-register 32x32->64 multiply cell: shadows the cell
// pipeline, picks the lo/hi product word and buffers results in a 2-entry shift FIFO.
module nios_mul_result_stage #(
    parameter int TAG_W = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    nios_mul_if.slave   bus,
    output logic [31:0] mul_src1,
    output logic [31:0] mul_src2,
    output logic        mul_src1_signed,
    output logic        mul_src2_signed,
    output logic        mul_m_en,
    output logic        mul_a_en,
    input  logic [63:0] mul_result,
    output logic        busy
);
    localparam logic [1:0] OP_MUL    = 2'd0;
    localparam logic [1:0] OP_MULXSS = 2'd1;
    localparam logic [1:0] OP_MULXSU = 2'd2;

    function automatic logic [31:0] select_word(input logic [1:0] op, input logic [63:0] prod);
        return (op == OP_MUL) ? prod[31:0] : prod[63:32];
    endfunction

    logic             vld_p1, vld_p2;
    logic [1:0]       op_p1, op_p2;
    logic [TAG_W-1:0] tag_p1, tag_p2;

    logic [1:0]       fifo_count;
    logic [31:0]      head_data, tail_data;
    logic [TAG_W-1:0] head_tag, tail_tag;

    logic        pop, adv, run, push;
    logic [31:0] push_word;

    assign pop       = bus.rsp_valid & bus.rsp_ready;
    assign adv       = ~vld_p2 | (fifo_count < 2'd2) | pop;
    assign run       = adv & ~reset & ~flush;
    assign push      = run & vld_p2;
    assign push_word = select_word(op_p2, mul_result);

    assign bus.req_ready = run;
    assign mul_m_en      = run;
    assign mul_a_en      = run;

    assign mul_src1        = bus.req_src1;
    assign mul_src2        = bus.req_src2;
    assign mul_src1_signed = (bus.req_op == OP_MULXSS) | (bus.req_op == OP_MULXSU);
    assign mul_src2_signed = (bus.req_op == OP_MULXSS);

    assign bus.rsp_valid = (fifo_count != 2'd0);
    assign bus.rsp_data  = head_data;
    assign bus.rsp_tag   = head_tag;
    assign busy          = vld_p1 | vld_p2 | (fifo_count != 2'd0);

    // p1/p2: shadow of the cell's input and output registers
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            vld_p1     <= 1'b0;
            vld_p2     <= 1'b0;
            fifo_count <= 2'd0;
        end else begin
            if (adv) begin
                vld_p1 <= bus.req_valid;
                vld_p2 <= vld_p1;
            end
            fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (run) begin
            op_p1  <= bus.req_op;
            tag_p1 <= bus.req_tag;
            op_p2  <= op_p1;
            tag_p2 <= tag_p1;
        end
    end

    // FIFO: head keeps its contents once drained, so rsp_data holds the last popped word
    always_ff @(posedge clk) begin
        if (reset) begin
            head_data <= 32'd0;
            head_tag  <= '0;
        end else if (!flush) begin
            if (push && ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop))) begin
                head_data <= push_word;
                head_tag  <= tag_p2;
            end else if (pop && (fifo_count == 2'd2)) begin
                head_data <= tail_data;
                head_tag  <= tail_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !flush && push &&
            (((fifo_count == 2'd1) && !pop) || ((fifo_count == 2'd2) && pop))) begin
            tail_data <= push_word;
            tail_tag  <= tag_p2;
        end
    end
endmodule

// File: tb/tb_nios_mul_result_stage.sv
// Directed bench for nios_mul_result_stage with a behavioural two-register multiply cell.
module tb_nios_mul_result_stage;
    localparam int TAG_W = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] mul_src1, mul_src2;
    logic        mul_src1_signed, mul_src2_signed, mul_m_en, mul_a_en;
    logic [63:0] mul_result;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    nios_mul_if #(.TAG_W(TAG_W)) bus ();

    nios_mul_result_stage #(.TAG_W(TAG_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .flush           (flush),
        .bus             (bus),
        .mul_src1        (mul_src1),
        .mul_src2        (mul_src2),
        .mul_src1_signed (mul_src1_signed),
        .mul_src2_signed (mul_src2_signed),
        .mul_m_en        (mul_m_en),
        .mul_a_en        (mul_a_en),
        .mul_result      (mul_result),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    // Behavioural multiply cell: input register on ena0, product register on ena1
    logic [31:0] cell_a, cell_b;
    logic        cell_sa, cell_sb;
    logic [63:0] cell_prod;

    function automatic logic [63:0] ext64(input logic [31:0] v, input logic s);
        return {{32{s & v[31]}}, v};
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            cell_a    <= 32'd0;
            cell_b    <= 32'd0;
            cell_sa   <= 1'b0;
            cell_sb   <= 1'b0;
            cell_prod <= 64'd0;
        end else begin
            if (mul_m_en) begin
                cell_a  <= mul_src1;
                cell_b  <= mul_src2;
                cell_sa <= mul_src1_signed;
                cell_sb <= mul_src2_signed;
            end
            if (mul_a_en) cell_prod <= ext64(cell_a, cell_sa) * ext64(cell_b, cell_sb);
        end
    end
    assign mul_result = cell_prod;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic v, input logic [1:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [TAG_W-1:0] tag);
        bus.req_valid = v;
        bus.req_op    = op;
        bus.req_src1  = a;
        bus.req_src2  = b;
        bus.req_tag   = tag;
    endtask

    task automatic issue_single(input string name, input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [TAG_W-1:0] tag,
                                input logic [31:0] exp);
        bus.rsp_ready = 1'b1;
        drive_req(1'b1, op, a, b, tag);
        #1;
        n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL %s req_ready: got %b want 1", name, bus.req_ready); end
        cyc();
        bus.req_valid = 1'b0;
        #1;
        n_tests++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL %s rsp_valid_c1: got %b want 0", name, bus.rsp_valid); end
        cyc(); #1;
        n_tests++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL %s rsp_valid_c2: got %b want 0", name, bus.rsp_valid); end
        cyc(); #1;
        n_tests++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL %s rsp_valid_c3: got %b want 1", name, bus.rsp_valid); end
        n_tests++; if (bus.rsp_data !== exp) begin n_fail++; $display("FAIL %s rsp_data: got %h want %h", name, bus.rsp_data, exp); end
        n_tests++; if (bus.rsp_tag !== tag) begin n_fail++; $display("FAIL %s rsp_tag: got %0d want %0d", name, bus.rsp_tag, tag); end
        cyc(); #1;
        n_tests++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL %s rsp_valid_after_pop: got %b want 0", name, bus.rsp_valid); end
        n_tests++; if (bus.rsp_data !== exp) begin n_fail++; $display("FAIL %s rsp_data_hold: got %h want %h", name, bus.rsp_data, exp); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_idle: got %b want 0", name, busy); end
    endtask

    task automatic check_reset_outputs(input string name);
        n_tests++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL %s rsp_valid: got %b want 0", name, bus.rsp_valid); end
        n_tests++; if (bus.rsp_data !== 32'd0) begin n_fail++; $display("FAIL %s rsp_data: got %h want 0", name, bus.rsp_data); end
        n_tests++; if (bus.rsp_tag !== '0) begin n_fail++; $display("FAIL %s rsp_tag: got %0d want 0", name, bus.rsp_tag); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s busy: got %b want 0", name, busy); end
        n_tests++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL %s req_ready: got %b want 0", name, bus.req_ready); end
        n_tests++; if (mul_m_en !== 1'b0) begin n_fail++; $display("FAIL %s mul_m_en: got %b want 0", name, mul_m_en); end
        n_tests++; if (mul_a_en !== 1'b0) begin n_fail++; $display("FAIL %s mul_a_en: got %b want 0", name, mul_a_en); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.rsp_ready = 1'b0;
        drive_req(1'b0, 2'd0, 32'd0, 32'd0, '0);
        repeat (3) cyc();
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;
        #1;
        n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release req_ready: got %b want 1", bus.req_ready); end
        cyc();
    endtask

    task automatic test_mul_lo();
        issue_single("mul_lo", 2'd0, 32'h0000_0003, 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFD);
    endtask

    task automatic test_signedness();
        issue_single("mulxss_m1", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'h0000_0000);
        issue_single("mulxsu_m1", 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFF);
        issue_single("mulxuu_m1", 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE);
        issue_single("mulxss_min", 2'd1, 32'h8000_0000, 32'h8000_0000, 5'd4, 32'h4000_0000);
    endtask

    task automatic test_back_to_back();
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 13; c++) begin
            if (c < 8) drive_req(1'b1, 2'd0, 32'(c + 1), 32'd3, TAG_W'(c));
            else       drive_req(1'b0, 2'd0, 32'd0, 32'd0, '0);
            #1;
            if (c < 8) begin
                n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b req_ready c%0d: got %b want 1", c, bus.req_ready); end
            end
            n_tests++;
            if (bus.rsp_valid !== ((c >= 3) && (c < 11))) begin
                n_fail++; $display("FAIL b2b rsp_valid c%0d: got %b want %b", c, bus.rsp_valid, ((c >= 3) && (c < 11)));
            end else if (bus.rsp_valid) begin
                n_tests++; if (bus.rsp_tag !== TAG_W'(c - 3)) begin n_fail++; $display("FAIL b2b rsp_tag c%0d: got %0d want %0d", c, bus.rsp_tag, c - 3); end
                n_tests++; if (bus.rsp_data !== 32'((c - 2) * 3)) begin n_fail++; $display("FAIL b2b rsp_data c%0d: got %0d want %0d", c, bus.rsp_data, (c - 2) * 3); end
            end
            cyc();
        end
    endtask

    task automatic test_backpressure();
        int accepted = 0;
        int got = 0;
        bus.rsp_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            drive_req(1'b1, 2'd0, 32'(10 + accepted), 32'd5, TAG_W'(10 + accepted));
            #1;
            if (bus.req_ready) accepted++;
            cyc();
        end
        #1;
        n_tests++; if (accepted != 4) begin n_fail++; $display("FAIL bp accepted: got %0d want 4", accepted); end
        n_tests++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL bp req_ready_full: got %b want 0", bus.req_ready); end
        n_tests++; if (mul_m_en !== 1'b0) begin n_fail++; $display("FAIL bp mul_m_en_full: got %b want 0", mul_m_en); end
        n_tests++; if (mul_a_en !== 1'b0) begin n_fail++; $display("FAIL bp mul_a_en_full: got %b want 0", mul_a_en); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bp busy_full: got %b want 1", busy); end
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c == 0) drive_req(1'b1, 2'd0, 32'd14, 32'd5, 5'd14);
            else        drive_req(1'b0, 2'd0, 32'd0, 32'd0, '0);
            #1;
            if (c == 0) begin
                n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL bp req_ready_on_pop: got %b want 1", bus.req_ready); end
            end
            if (bus.rsp_valid) begin
                n_tests++; if (bus.rsp_tag !== TAG_W'(10 + got)) begin n_fail++; $display("FAIL bp drain_tag %0d: got %0d want %0d", got, bus.rsp_tag, 10 + got); end
                n_tests++; if (bus.rsp_data !== 32'((10 + got) * 5)) begin n_fail++; $display("FAIL bp drain_data %0d: got %0d want %0d", got, bus.rsp_data, (10 + got) * 5); end
                got++;
            end
            cyc();
        end
        #1;
        n_tests++; if (got != 5) begin n_fail++; $display("FAIL bp drained: got %0d want 5", got); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp busy_drained: got %b want 0", busy); end
    endtask

    task automatic test_flush();
        bus.rsp_ready = 1'b1;
        drive_req(1'b1, 2'd0, 32'd9, 32'd9, 5'd20);
        cyc();
        drive_req(1'b1, 2'd0, 32'd8, 32'd8, 5'd21);
        cyc();
        drive_req(1'b1, 2'd0, 32'd7, 32'd7, 5'd22);
        flush = 1'b1;
        #1;
        n_tests++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL flush req_ready: got %b want 0", bus.req_ready); end
        n_tests++; if (mul_m_en !== 1'b0) begin n_fail++; $display("FAIL flush mul_m_en: got %b want 0", mul_m_en); end
        n_tests++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL flush rsp_valid: got %b want 0", bus.rsp_valid); end
        cyc();
        flush = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush busy_next: got %b want 0", busy); end
        for (int c = 0; c < 5; c++) begin
            n_tests++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL flush stale_rsp c%0d: got %b want 0", c, bus.rsp_valid); end
            cyc(); #1;
        end
        issue_single("after_flush", 2'd0, 32'd7, 32'd6, 5'd3, 32'd42);
    endtask

    task automatic test_reset_midop();
        bus.rsp_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            drive_req(1'b1, 2'd0, 32'd3, 32'd3, TAG_W'(24 + c));
            cyc();
        end
        bus.req_valid = 1'b0;
        #1;
        n_tests++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rst_mid pre_rsp_valid: got %b want 1", bus.rsp_valid); end
        reset = 1'b1;
        cyc(); #1;
        check_reset_outputs("rst_mid");
        reset = 1'b0;
        issue_single("after_reset", 2'd0, 32'd2, 32'd2, 5'd9, 32'd4);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = 2'd0;
        bus.req_tag   = '0;
        bus.req_src1  = 32'd0;
        bus.req_src2  = 32'd0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_mul_lo();
        test_signedness();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
